// File: rtl/tpu_job_sequencer.sv
// Job sequencer for the memory-mapped 8x8 TPU: clears C, loads A and B, runs the matmul,
// waits out the run counter and drains C over a valid/ready stream. Sole master of the TPU port.
//
// state | meaning
// IDLE  | waiting for start, TPU port parked at the idle address
// CLRC  | writing zero to the 16 C half-rows
// LDA   | writing 8 A rows from the input stream
// LDB   | shifting 8 B words into memB from the input stream
// MMS   | single matmul start command
// MMW   | waiting MM_WAIT cycles for the TPU run counter
// RDC   | reading 16 C half-rows into the output register
// DONE  | draining the last word, then pulsing done
module tpu_job_sequencer #(
    parameter int DIM     = 8,
    parameter int DATAW   = 64,
    parameter int ADDRW   = 16,
    parameter int MM_WAIT = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_done,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [DATAW-1:0] i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [DATAW-1:0] o_out_data,
    output logic             o_tpu_r_w,
    output logic [ADDRW-1:0] o_tpu_addr,
    output logic [DATAW-1:0] o_tpu_dataIn,
    input  logic [DATAW-1:0] i_tpu_dataOut
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CLRC = 3'd1;
    localparam logic [2:0] S_LDA  = 3'd2;
    localparam logic [2:0] S_LDB  = 3'd3;
    localparam logic [2:0] S_MMS  = 3'd4;
    localparam logic [2:0] S_MMW  = 3'd5;
    localparam logic [2:0] S_RDC  = 3'd6;
    localparam logic [2:0] S_DONE = 3'd7;

    localparam logic [4:0] IDX_LAST_C  = 5'(2 * DIM - 1);
    localparam logic [4:0] IDX_LAST_AB = 5'(DIM - 1);
    localparam logic [4:0] IDX_LAST_W  = 5'(MM_WAIT - 1);

    localparam logic [ADDRW-1:0] A_BASE  = ADDRW'(16'h0100);
    localparam logic [ADDRW-1:0] B_ADDR  = ADDRW'(16'h0200);
    localparam logic [ADDRW-1:0] C_BASE  = ADDRW'(16'h0300);
    localparam logic [ADDRW-1:0] MM_ADDR = ADDRW'(16'h0400);

    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [4:0]       r_idx;
    logic [4:0]       w_next_idx;
    logic             r_abort_pend;
    logic             r_busy;
    logic             r_done;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [DATAW-1:0] r_out_data;
    logic             w_capture;
    logic             w_abort_kill;
    logic [ADDRW-1:0] w_c_addr;
    logic [ADDRW-1:0] w_a_addr;

    assign w_capture    = (r_state == S_RDC) && (!r_out_valid || i_out_ready);
    // The matmul run counter must never be cut short, so abort is deferred through MMS/MMW.
    assign w_abort_kill = i_abort && (r_state != S_MMS) && (r_state != S_MMW);
    assign w_c_addr     = C_BASE | ADDRW'({r_idx[3:0], 3'b000});
    assign w_a_addr     = A_BASE | ADDRW'({r_idx[2:0], 3'b000});

    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = S_CLRC;
                    w_next_idx   = 5'd0;
                end
            end
            S_CLRC: begin
                if (r_idx == IDX_LAST_C) begin
                    w_next_state = S_LDA;
                    w_next_idx   = 5'd0;
                end else begin
                    w_next_idx = r_idx + 5'd1;
                end
            end
            S_LDA: begin
                if (i_in_valid) begin
                    if (r_idx == IDX_LAST_AB) begin
                        w_next_state = S_LDB;
                        w_next_idx   = 5'd0;
                    end else begin
                        w_next_idx = r_idx + 5'd1;
                    end
                end
            end
            S_LDB: begin
                if (i_in_valid) begin
                    if (r_idx == IDX_LAST_AB) begin
                        w_next_state = S_MMS;
                        w_next_idx   = 5'd0;
                    end else begin
                        w_next_idx = r_idx + 5'd1;
                    end
                end
            end
            S_MMS: begin
                w_next_state = S_MMW;
                w_next_idx   = 5'd0;
            end
            S_MMW: begin
                if (r_idx == IDX_LAST_W) begin
                    w_next_state = (r_abort_pend || i_abort) ? S_IDLE : S_RDC;
                    w_next_idx   = 5'd0;
                end else begin
                    w_next_idx = r_idx + 5'd1;
                end
            end
            S_RDC: begin
                if (w_capture) begin
                    if (r_idx == IDX_LAST_C) begin
                        w_next_state = S_DONE;
                        w_next_idx   = 5'd0;
                    end else begin
                        w_next_idx = r_idx + 5'd1;
                    end
                end
            end
            S_DONE: begin
                if (r_done) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_idx   = 5'd0;
            end
        endcase
        if (w_abort_kill) begin
            w_next_state = S_IDLE;
            w_next_idx   = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= 5'd0;
            r_abort_pend <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
        end else begin
            r_state    <= w_next_state;
            r_idx      <= w_next_idx;
            r_busy     <= (w_next_state != S_IDLE);
            r_in_ready <= (w_next_state == S_LDA) || (w_next_state == S_LDB);
            r_done     <= (r_state == S_DONE) && !r_done && !i_abort
                          && (!r_out_valid || i_out_ready);

            if ((w_next_state == S_IDLE) || (w_next_state == S_RDC)) begin
                r_abort_pend <= 1'b0;
            end else if (i_abort && ((r_state == S_MMS) || (r_state == S_MMW))) begin
                r_abort_pend <= 1'b1;
            end

            if (w_abort_kill) begin
                r_out_valid <= 1'b0;
            end else if (w_capture) begin
                r_out_data  <= i_tpu_dataOut;
                r_out_valid <= 1'b1;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Any cycle without an active access parks on address 0: 0x2xx shifts B, 0x4xx restarts the run.
    always_comb begin
        o_tpu_r_w    = 1'b0;
        o_tpu_addr   = '0;
        o_tpu_dataIn = '0;
        case (r_state)
            S_CLRC: begin
                o_tpu_r_w  = 1'b1;
                o_tpu_addr = w_c_addr;
            end
            S_LDA: begin
                if (i_in_valid) begin
                    o_tpu_r_w    = 1'b1;
                    o_tpu_addr   = w_a_addr;
                    o_tpu_dataIn = i_in_data;
                end
            end
            S_LDB: begin
                if (i_in_valid) begin
                    o_tpu_r_w    = 1'b1;
                    o_tpu_addr   = B_ADDR;
                    o_tpu_dataIn = i_in_data;
                end
            end
            S_MMS: begin
                o_tpu_r_w  = 1'b1;
                o_tpu_addr = MM_ADDR;
            end
            S_RDC: begin
                o_tpu_addr = w_c_addr;
            end
            default: begin
                o_tpu_r_w = 1'b0;
            end
        endcase
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;

endmodule

// File: tb/tb_tpu_job_sequencer.sv
// Bench for tpu_job_sequencer: behavioural TPU memory model plus directed jobs,
// a checkpoint table for the unstalled job and hand-written abort/reset/stall sequences.
module tb_tpu_job_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] in_data = '0;
    logic        busy, done, in_ready, out_valid, tpu_r_w;
    logic [63:0] out_data, tpu_dataIn, tpu_dataOut;
    logic [15:0] tpu_addr;

    always #5 clk = ~clk;

    tpu_job_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (start),
        .i_abort      (abort),
        .o_busy       (busy),
        .o_done       (done),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_data    (in_data),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_data   (out_data),
        .o_tpu_r_w    (tpu_r_w),
        .o_tpu_addr   (tpu_addr),
        .o_tpu_dataIn (tpu_dataIn),
        .i_tpu_dataOut(tpu_dataOut)
    );

    // TPU memory model: A rows, B shift register (first word ends in row 0), accumulating C.
    logic [7:0]  m_a [8][8];
    logic [7:0]  m_b [8][8];
    logic [15:0] m_c [8][8];

    always @(posedge clk) begin
        if (tpu_r_w) begin
            if (tpu_addr[15:8] == 8'h01) begin
                for (int k = 0; k < 8; k++) m_a[tpu_addr[5:3]][k] <= tpu_dataIn[8*k +: 8];
            end else if (tpu_addr == 16'h0200) begin
                for (int r = 0; r < 7; r++)
                    for (int k = 0; k < 8; k++) m_b[r][k] <= m_b[r+1][k];
                for (int k = 0; k < 8; k++) m_b[7][k] <= tpu_dataIn[8*k +: 8];
            end else if (tpu_addr[15:8] == 8'h03) begin
                for (int k = 0; k < 4; k++)
                    m_c[tpu_addr[6:4]][4*tpu_addr[3] + k] <= tpu_dataIn[16*k +: 16];
            end else if (tpu_addr == 16'h0400) begin
                for (int r = 0; r < 8; r++)
                    for (int c = 0; c < 8; c++) begin
                        int acc;
                        acc = 0;
                        for (int k = 0; k < 8; k++) acc += int'(m_a[r][k]) * int'(m_b[k][c]);
                        m_c[r][c] <= 16'(int'(m_c[r][c]) + acc);
                    end
            end
        end
    end

    always_comb begin
        tpu_dataOut = '0;
        if (tpu_addr[15:8] == 8'h03)
            for (int k = 0; k < 4; k++)
                tpu_dataOut[16*k +: 16] = m_c[tpu_addr[6:4]][4*tpu_addr[3] + k];
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [15:0] addr;
        logic        rw;
        logic        busy;
        logic        done;
        logic        ov;
        logic        ir;
    } cp_t;

    logic [63:0] src [16];
    int          src_idx;
    logic [63:0] out_words [$];
    logic [16:0] bus [$];
    int          done_cyc, done_cnt, words_at_done;
    int          n200, n200_stall, nread, idle_viol, hold_viol;
    logic        snap_busy [200];
    logic        snap_done [200];
    logic        snap_ov   [200];
    logic        snap_ir   [200];
    logic        snap_rw   [200];
    logic [15:0] snap_addr [200];
    logic [63:0] snap_din  [200];
    logic [63:0] snap_data [200];

    function automatic logic [63:0] exp_word(input int scale, input int n);
        logic [63:0] w;
        int r, h;
        r = n / 2;
        h = n % 2;
        w = '0;
        for (int k = 0; k < 4; k++) w[16*k +: 16] = 16'(scale * (r + 8 * (4*h + k)));
        return w;
    endfunction

    // Cycle 0 is the cycle in which start is presented with the sequencer in IDLE.
    task automatic run_job(input int scale, input bit toggle, input int st_lo, input int st_hi,
                           input int ab_cyc, input int rs_cyc, input int xs_cyc, input int ncyc);
        logic        prev_hold, acc_in;
        logic [63:0] prev_data;
        for (int r = 0; r < 8; r++) begin
            src[r] = '0;
            src[r][8*r +: 8] = 8'(scale);
        end
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) src[8+i][8*j +: 8] = 8'(i + 8*j);
        src_idx = 0;
        out_words.delete();
        bus.delete();
        done_cyc = -1; done_cnt = 0; words_at_done = -1;
        n200 = 0; n200_stall = 0; nread = 0; idle_viol = 0; hold_viol = 0;
        prev_hold = 1'b0;
        prev_data = '0;
        for (int c = 0; c < ncyc; c++) begin
            start     = (c == 0) || (c == xs_cyc);
            abort     = (c == ab_cyc);
            rst_n     = (c != rs_cyc);
            in_valid  = toggle ? ((c % 2) == 0) : 1'b1;
            in_data   = (src_idx < 16) ? src[src_idx] : '0;
            out_ready = !(c >= st_lo && c <= st_hi);
            @(negedge clk);
            snap_busy[c] = busy;  snap_done[c] = done;  snap_ov[c] = out_valid;
            snap_ir[c] = in_ready; snap_rw[c] = tpu_r_w; snap_addr[c] = tpu_addr;
            snap_din[c] = tpu_dataIn; snap_data[c] = out_data;
            if (done) begin
                if (done_cyc < 0) begin
                    done_cyc = c;
                    words_at_done = out_words.size();
                end
                done_cnt++;
            end
            if (out_valid && out_ready) out_words.push_back(out_data);
            if (tpu_addr != 16'h0000) bus.push_back({tpu_r_w, tpu_addr});
            if (tpu_addr == 16'h0200) begin
                n200++;
                if (!in_valid) n200_stall++;
            end
            if (tpu_addr[15:8] == 8'h03 && !tpu_r_w) nread++;
            if (tpu_addr == 16'h0000 && (tpu_r_w || tpu_dataIn != '0)) idle_viol++;
            if (prev_hold && (!out_valid || out_data != prev_data)) hold_viol++;
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            acc_in = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc_in) src_idx++;
        end
        start = 1'b0;
        abort = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic check_words(input string tag, input int scale);
        chk({tag, "_nwords"}, 64'(out_words.size()), 64'd16);
        for (int n = 0; n < out_words.size() && n < 16; n++)
            chk($sformatf("%s_word%0d", tag, n), out_words[n], exp_word(scale, n));
        chk({tag, "_idle_bus"}, 64'(idle_viol), 64'd0);
    endtask

    cp_t         tab [17];
    logic [16:0] exp_bus [$];
    int          mism;

    initial begin
        tab[0]  = '{0,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab[1]  = '{1,  16'h0300, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[2]  = '{2,  16'h0308, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[3]  = '{16, 16'h0378, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[4]  = '{17, 16'h0100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tab[5]  = '{24, 16'h0138, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tab[6]  = '{25, 16'h0200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tab[7]  = '{32, 16'h0200, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tab[8]  = '{33, 16'h0400, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[9]  = '{34, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[10] = '{65, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[11] = '{66, 16'h0300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tab[12] = '{67, 16'h0308, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tab[13] = '{81, 16'h0378, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tab[14] = '{82, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tab[15] = '{83, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tab[16] = '{84, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int n = 0; n < 16; n++) exp_bus.push_back({1'b1, 16'(16'h0300 | (n << 3))});
        for (int r = 0; r < 8; r++)  exp_bus.push_back({1'b1, 16'(16'h0100 | (r << 3))});
        for (int i = 0; i < 8; i++)  exp_bus.push_back({1'b1, 16'h0200});
        exp_bus.push_back({1'b1, 16'h0400});
        for (int n = 0; n < 16; n++) exp_bus.push_back({1'b0, 16'(16'h0300 | (n << 3))});

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_tpu_addr", 64'(tpu_addr), 64'd0);
        chk("rst_tpu_rw", 64'(tpu_r_w), 64'd0);
        chk("rst_tpu_din", tpu_dataIn, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic unstalled job, checkpoint table
        run_job(1, 1'b0, -1, -1, -1, -1, -1, 90);
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("basic_c%0d_addr", tab[i].cyc), 64'(snap_addr[tab[i].cyc]), 64'(tab[i].addr));
            chk($sformatf("basic_c%0d_rw", tab[i].cyc), 64'(snap_rw[tab[i].cyc]), 64'(tab[i].rw));
            chk($sformatf("basic_c%0d_busy", tab[i].cyc), 64'(snap_busy[tab[i].cyc]), 64'(tab[i].busy));
            chk($sformatf("basic_c%0d_done", tab[i].cyc), 64'(snap_done[tab[i].cyc]), 64'(tab[i].done));
            chk($sformatf("basic_c%0d_ov", tab[i].cyc), 64'(snap_ov[tab[i].cyc]), 64'(tab[i].ov));
            chk($sformatf("basic_c%0d_ir", tab[i].cyc), 64'(snap_ir[tab[i].cyc]), 64'(tab[i].ir));
        end
        chk("basic_clr_din", snap_din[1], 64'd0);
        chk("basic_a0_din", snap_din[17], src[0]);
        chk("basic_b7_din", snap_din[32], src[15]);
        check_words("basic", 1);
        chk("basic_done_cyc", 64'(done_cyc), 64'd83);
        chk("basic_done_cnt", 64'(done_cnt), 64'd1);
        chk("basic_bus_len", 64'(bus.size()), 64'(exp_bus.size()));
        mism = 0;
        for (int i = 0; i < bus.size() && i < exp_bus.size(); i++)
            if (bus[i] !== exp_bus[i]) mism++;
        chk("basic_bus_seq", 64'(mism), 64'd0);

        // Input stalls: in_valid toggles 1010..., 16 stall cycles in LDA+LDB
        run_job(1, 1'b1, -1, -1, -1, -1, -1, 120);
        chk("stall_n200", 64'(n200), 64'd8);
        chk("stall_200_in_gap", 64'(n200_stall), 64'd0);
        check_words("stall", 1);
        chk("stall_done_cyc", 64'(done_cyc), 64'd99);

        // Output backpressure for 5 cycles in RDC, plus start pulses while busy
        run_job(1, 1'b0, 70, 74, -1, -1, 10, 100);
        chk("bp_hold", 64'(hold_viol), 64'd0);
        check_words("bp", 1);
        chk("bp_nread", 64'(nread), 64'd21);
        chk("bp_done_cyc", 64'(done_cyc), 64'd88);
        chk("bp_words_at_done", 64'(words_at_done), 64'd16);
        chk("bp_done_cnt", 64'(done_cnt), 64'd1);

        // Back-to-back job with A = 2*I; C was left holding B
        run_job(2, 1'b0, -1, -1, -1, -1, -1, 90);
        check_words("b2b", 2);
        chk("b2b_done_cyc", 64'(done_cyc), 64'd83);

        // Abort in LDA
        run_job(1, 1'b0, -1, -1, 20, -1, -1, 30);
        chk("abA_busy20", 64'(snap_busy[20]), 64'd1);
        chk("abA_busy21", 64'(snap_busy[21]), 64'd0);
        chk("abA_ir21", 64'(snap_ir[21]), 64'd0);
        chk("abA_addr21", 64'(snap_addr[21]), 64'd0);
        chk("abA_done_cnt", 64'(done_cnt), 64'd0);

        // start together with abort in IDLE
        run_job(1, 1'b0, -1, -1, 0, -1, -1, 5);
        chk("sa_busy1", 64'(snap_busy[1]), 64'd0);
        chk("sa_addr1", 64'(snap_addr[1]), 64'd0);

        // Abort in MMW: full wait, then IDLE with no reads
        run_job(1, 1'b0, -1, -1, 40, -1, -1, 90);
        chk("abW_busy65", 64'(snap_busy[65]), 64'd1);
        chk("abW_busy66", 64'(snap_busy[66]), 64'd0);
        chk("abW_addr66", 64'(snap_addr[66]), 64'd0);
        chk("abW_nread", 64'(nread), 64'd0);
        chk("abW_done_cnt", 64'(done_cnt), 64'd0);
        chk("abW_nwords", 64'(out_words.size()), 64'd0);

        // Synchronous reset mid-job, then a fresh job
        run_job(1, 1'b0, -1, -1, -1, 40, -1, 45);
        chk("rmj_busy", 64'(snap_busy[41]), 64'd0);
        chk("rmj_done", 64'(snap_done[41]), 64'd0);
        chk("rmj_ir", 64'(snap_ir[41]), 64'd0);
        chk("rmj_ov", 64'(snap_ov[41]), 64'd0);
        chk("rmj_out_data", snap_data[41], 64'd0);
        chk("rmj_addr", 64'(snap_addr[41]), 64'd0);
        chk("rmj_rw", 64'(snap_rw[41]), 64'd0);
        chk("rmj_din", snap_din[41], 64'd0);
        run_job(1, 1'b0, -1, -1, -1, -1, -1, 90);
        check_words("post_rst", 1);
        chk("post_rst_done_cyc", 64'(done_cyc), 64'd83);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tpu_job_sequencer.md
# tpu_job_sequencer

Sequences one complete 8x8 matrix-multiply job on the memory-mapped TPU core: clears the C accumulators, streams A rows and B rows in from a valid/ready input, fires the matmul, waits it out, then streams the 16 C half-rows out on a valid/ready output. It sits between the host/DMA stream logic and the TPU's `r_w`/`addr`/`dataIn`/`dataOut` port, and is the only master of that port.

## Interface
- DIM, 8, matrix dimension. The TPU address map fixes this value.
- DATAW, 64, TPU data word width.
- ADDRW, 16, TPU address width.
- MM_WAIT, 32, idle cycles after the matmul command before C is read. This covers the TPU's internal run counter.

- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- start  in  1  begin a job. Sampled only in IDLE; ignored otherwise.
- abort  in  1  abandon the current job.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at job completion.
- in_valid / in_ready  in/out  1/1  A/B word handshake.
- in_data  in  DATAW  A row or B word. Element k is at [8k+7:8k].
- out_valid / out_ready  out/in  1/1  C half-row handshake.
- out_data  out  DATAW  C half-row. Column (4h+k) is at [16k+15:16k].
- tpu_r_w  out  1  1 = write, 0 = read.
- tpu_addr  out  ADDRW  TPU address.
- tpu_dataIn  out  DATAW  write data to the TPU.
- tpu_dataOut  in  DATAW  TPU read data, combinational from tpu_addr.

## Operation
- TPU address map:
  - A row r write: 0x100 | r<<3.
  - B word write: 0x200. Each cycle at this address shifts memB.
  - C row r, half h: 0x300 | r<<4 | h<<3.
  - Matmul start: 0x400.
- Idle address is 0x000, with tpu_r_w=0 and tpu_dataIn=0. It is driven in every cycle that is not an active access. Holding 0x2xx or 0x4xx outside an active access corrupts B or restarts the matmul.
- tpu_* outputs are combinational from state, index, in_valid and in_data. All other outputs are registered.
- One 5-bit index counter idx is shared across states.
- States and transitions:
  - IDLE: start → CLRC, idx=0.
  - CLRC: write zero to C half idx (row=idx[3:1], h=idx[0]), r_w=1, one per cycle. Exit after idx=15 → LDA.
  - LDA: in_ready=1. On in_valid, write in_data to A row idx and increment idx. Exit after row 7 → LDB.
  - LDB: in_ready=1. On in_valid, write to 0x200. When in_valid=0, drive the idle address; B does not shift. Exit after 8 words → MMS.
  - MMS: one cycle at 0x400 → MMW.
  - MMW: idle address for MM_WAIT cycles → RDC.
  - RDC: drive the read address for half idx with r_w=0. Capture occurs when (!out_valid || out_ready); the cycle then registers tpu_dataOut into out_data and sets out_valid. The address advances only on capture. Exit after the 16th capture → DONE.
  - DONE: when out_valid=0 (last word drained), done=1 for one cycle → IDLE.
- out_valid clears on out_ready when no new capture occurs in that cycle. out_data is stable while out_valid && !out_ready.
- abort:
  - In any state except MMS/MMW: → IDLE next cycle. out_valid clears, and done is not pulsed.
  - In MMS/MMW: abort is latched and honored when MMW completes, so the TPU run counter is never truncated.
- start together with abort in IDLE: abort wins; the sequencer stays in IDLE.

## Timing
- Reset values:
  - state=IDLE, idx=0, abort latch=0.
  - busy=0, done=0, in_ready=0, out_valid=0, out_data=0.
  - tpu_addr=0x000, tpu_r_w=0, tpu_dataIn=0.
- Reset mid-job returns to IDLE in one cycle with the idle address.
- Ideal job, with in_valid and out_ready held high and start accepted in cycle 0:
  - CLRC: cycles 1–16.
  - LDA: cycles 17–24.
  - LDB: cycles 25–32.
  - MMS: cycle 33.
  - MMW: cycles 34–65.
  - RDC: cycles 66–81. out_valid is high in cycles 67–82.
  - DONE: cycles 82–83. done=1 in cycle 83.
  - IDLE: cycle 84.
- Input stalls add one cycle each. Output stalls hold the read address and RDC.
- busy drops in the cycle after the done pulse.

## Test plan
- **Basic job:** A=identity, B[i][j]=i+8j, streams unstalled. Required: 16 out words matching B; done in cycle 83; tpu_addr sequence exactly as in the map.
- **Input stalls in LDB:** in_valid toggles 1010…. Required: 0x200 appears exactly 8 times, never during a stall cycle; result unchanged.
- **Output backpressure:** out_ready low for 5 cycles during RDC. Required: out_data stable while stalled, no words lost or duplicated, done only after the last word is accepted.
- **Back-to-back jobs:** second job uses A=2·I. Required: results equal 2·B, with no accumulation from the first job (CLRC works).
- **Abort:**
  - In LDA: IDLE next cycle, done=0.
  - In MMW: stays in MMW for the full 32 cycles, then IDLE, no RDC reads.
  - start while busy: ignored.
- **Reset:** rst_n low in cycle 40. Required: all outputs at reset values in the next cycle; a fresh start completes correctly.
